sim_data_checker: RTL
=====================

SIM_DATA_CHECKER -- requirements
Module: sim_data_checker

Interface
REQ-001 The block SHALL have a parameter CNT_W, default 32, giving the width of the word and error counters.
REQ-002 The block SHALL have a parameter LOSS_THRESH, default 4, giving the number of consecutive bad words that drops lock.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port En, input, 1 bit: arm request; its rising edge starts a check run.
REQ-006 The block SHALL have port DataIn, input, 32 bits: received word, expected to be the pattern {4{byte}}.
REQ-007 The block SHALL have port DataInValid, input, 1 bit: DataIn is qualified this cycle.
REQ-008 The block SHALL have port Locked, output, 1 bit: checker is synchronised to the stream.
REQ-009 The block SHALL have port WordCount, output, CNT_W bits: qualified words checked while locked.
REQ-010 The block SHALL have port ErrCount, output, CNT_W bits: bad words seen while locked.
REQ-011 The block SHALL have port ErrPulse, output, 1 bit: one-cycle strobe per bad word.
REQ-012 The block SHALL have port FirstErrData, output, 32 bits: first bad word of the current run.
REQ-013 The block SHALL have port FirstErrValid, output, 1 bit: FirstErrData holds a captured word.

Function
REQ-014 The block SHALL register En as EnReg and detect arming as En=1 with EnReg=0.
REQ-015 The FSM SHALL have three states: IDLE, SYNC and CHECK.
REQ-016 On arming from any state, the FSM SHALL enter SYNC and clear WordCount, ErrCount, FirstErrValid and the consecutive-error counter.
REQ-017 If En=0 in SYNC or CHECK, the FSM SHALL return to IDLE and deassert Locked, with the counters holding their values for readout.
REQ-018 A word SHALL be well-formed when all four bytes of DataIn are equal.
REQ-019 In SYNC, the first qualified well-formed word SHALL load expected = DataIn[7:0]+1 (mod 256), set Locked and move the FSM to CHECK; this word is not counted.
REQ-020 In SYNC, malformed words SHALL be ignored.
REQ-021 In CHECK, each qualified word SHALL increment WordCount.
REQ-022 In CHECK, a qualified word is good only if it is well-formed and DataIn[7:0]==expected.
REQ-023 The transition 0xFF->0x00 SHALL be treated as good.
REQ-024 On a good word, the block SHALL set expected to expected+1 and clear the consecutive-error counter.
REQ-025 On a bad word, the block SHALL increment ErrCount, pulse ErrPulse, set expected to DataIn[7:0]+1 (self-resync) and increment the consecutive-error counter.
REQ-026 On the first bad word of a run, the block SHALL capture it into FirstErrData and set FirstErrValid; later errors SHALL NOT overwrite the capture.
REQ-027 When the consecutive-error counter reaches LOSS_THRESH, the FSM SHALL deassert Locked and go to SYNC; counters SHALL hold, not clear.
REQ-028 Cycles with DataInValid=0 SHALL perform no check and SHALL leave expected unchanged, so gaps are legal.
REQ-029 WordCount and ErrCount SHALL saturate at all-ones and never wrap.
REQ-030 All outputs SHALL be registered, with exactly 1 cycle of latency from a qualified input to the counter, ErrPulse or Locked update.
REQ-031 If arming and DataInValid coincide, arming SHALL take priority and the word SHALL be treated as a SYNC-state word in the next cycle, i.e. dropped.

Reset
REQ-032 While rst=1, the block SHALL asynchronously force state IDLE and EnReg=0.
REQ-033 While rst=1, the block SHALL asynchronously force Locked=0, WordCount=0, ErrCount=0, ErrPulse=0, FirstErrData=0, FirstErrValid=0, expected=0 and the consecutive-error counter to 0.
REQ-034 Reset asserted mid-run SHALL abort the run, and after release the block SHALL stay in IDLE until a fresh En rising edge, with En held high across reset not counting as arming.

Structure
REQ-035 The package sim_data_pkg SHALL hold the FSM state enum, PAT_BYTE_W=8, WORD_W=32 and the default CNT_W and LOSS_THRESH.
REQ-036 One combinational sub-module, sim_data_word_check, SHALL produce well_formed and byte_match from DataIn and expected.

Verification
REQ-037 The bench SHALL drive En rising, then a clean stream of 300 words starting at byte 0x00, and SHALL see Locked=1 one cycle after the first word, WordCount=299 and ErrCount=0, confirming wrap-around.
REQ-038 The bench SHALL drive a clean stream, then replace byte 0x10 with 0x10101011, and SHALL see exactly one ErrPulse, ErrCount=1, FirstErrData=0x10101011, Locked staying 1, and the next word 0x12121212 judged good.
REQ-039 The bench SHALL drive a clean stream with DataInValid toggling 1-0-0-1, and SHALL see no errors, WordCount equal to the number of valid cycles minus 1, and expected unaffected by the gaps.
REQ-040 The bench SHALL drive 4 consecutive malformed words (0x01020304) while locked, and SHALL see ErrCount=4, Locked=0 on the cycle after the 4th word, then relock on the next well-formed word with ErrCount held at 4.
REQ-041 The bench SHALL assert rst mid-stream with En held high, and SHALL see all outputs at 0 immediately, the block remaining in IDLE after release, and a new run only after En goes 0 then 1.
REQ-042 The bench SHALL force the WordCount start value to all-ones minus 1 (CNT_W=8 build) and drive 5 good words, and SHALL see WordCount stay at 0xFF.

Source files
------------

// File: rtl/sim_data_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sim_data_pkg
// Description : Shared types and constants for the incrementing-byte stream
//               checker (FSM state encoding, pattern/word widths, defaults).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sim_data_pkg;

  localparam int PAT_BYTE_W      = 8;
  localparam int WORD_W          = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_LOSS_THRESH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage : sim_data_pkg
`default_nettype wire

// File: rtl/sim_data_word_check.sv
`default_nettype none
// ============================================================================
// Module      : sim_data_word_check
// Description : Combinational word classifier. A word is well formed when all
//               four bytes are identical; byte_match compares the low byte
//               against the currently expected pattern byte.
// Ports       : data_i        - received word
//               expected_i    - expected pattern byte
//               well_formed_o - all bytes of data_i equal
//               byte_match_o  - data_i[7:0] equals expected_i
// Revision    : 1.0 - initial release
// ============================================================================
module sim_data_word_check
  import sim_data_pkg::*;
(
  input  logic [WORD_W-1:0]     data_i,
  input  logic [PAT_BYTE_W-1:0] expected_i,
  output logic                  well_formed_o,
  output logic                  byte_match_o
);

  assign well_formed_o = (data_i[15:8]  == data_i[7:0]) &&
                         (data_i[23:16] == data_i[7:0]) &&
                         (data_i[31:24] == data_i[7:0]);

  assign byte_match_o  = (data_i[PAT_BYTE_W-1:0] == expected_i);

endmodule : sim_data_word_check
`default_nettype wire

// File: rtl/sim_data_checker.sv
`default_nettype none
// ============================================================================
// Module      : sim_data_checker
// Description : Checks a stream of {4{byte}} words whose byte increments by
//               one per qualified word. Locks on the first well-formed word,
//               counts words and errors (saturating), captures the first bad
//               word of a run and drops lock after LOSS_THRESH consecutive
//               bad words.
// Ports       : clk           - clock, rising edge
//               rst           - asynchronous active-high reset
//               En            - arm request, rising edge starts a run
//               DataIn        - received word
//               DataInValid   - DataIn qualified this cycle
//               Locked        - synchronised to the stream
//               WordCount     - qualified words checked while locked
//               ErrCount      - bad words seen while locked
//               ErrPulse      - one-cycle strobe per bad word
//               FirstErrData  - first bad word of the current run
//               FirstErrValid - FirstErrData holds a captured word
// Revision    : 1.0 - initial release
// ============================================================================
module sim_data_checker
  import sim_data_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic [WORD_W-1:0] DataIn,
  input  logic              DataInValid,
  output logic              Locked,
  output logic [CNT_W-1:0]  WordCount,
  output logic [CNT_W-1:0]  ErrCount,
  output logic              ErrPulse,
  output logic [WORD_W-1:0] FirstErrData,
  output logic              FirstErrValid
);

  localparam int CONS_W = $clog2(LOSS_THRESH + 1);

  state_e                state_q, state_d;
  logic                  en_q;
  logic                  en_ok_q;
  logic                  locked_q, locked_d;
  logic [CNT_W-1:0]      wc_q, wc_d;
  logic [CNT_W-1:0]      ec_q, ec_d;
  logic                  pulse_q, pulse_d;
  logic [WORD_W-1:0]     fed_q, fed_d;
  logic                  fev_q, fev_d;
  logic [PAT_BYTE_W-1:0] exp_q, exp_d;
  logic [CONS_W-1:0]     cons_q, cons_d;

  logic                  w_arm;
  logic                  w_well_formed;
  logic                  w_byte_match;
  logic [CONS_W-1:0]     w_cons_inc;

  sim_data_word_check u_word_check (
    .data_i        (DataIn),
    .expected_i    (exp_q),
    .well_formed_o (w_well_formed),
    .byte_match_o  (w_byte_match)
  );

  // en_ok_q stays low after reset until En has been seen low, so an En held
  // high across reset does not look like a fresh rising edge.
  assign w_arm      = En && !en_q && en_ok_q;
  assign w_cons_inc = cons_q + CONS_W'(1);

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    wc_d     = wc_q;
    ec_d     = ec_q;
    pulse_d  = 1'b0;
    fed_d    = fed_q;
    fev_d    = fev_q;
    exp_d    = exp_q;
    cons_d   = cons_q;

    if (w_arm) begin
      // Arming wins over a coincident qualified word, which is dropped.
      state_d  = ST_SYNC;
      locked_d = 1'b0;
      wc_d     = '0;
      ec_d     = '0;
      fev_d    = 1'b0;
      cons_d   = '0;
    end else if (!En && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (DataInValid && w_well_formed) begin
            exp_d    = DataIn[PAT_BYTE_W-1:0] + 8'd1;
            locked_d = 1'b1;
            cons_d   = '0;
            state_d  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (DataInValid) begin
            if (wc_q != '1) wc_d = wc_q + CNT_W'(1);
            if (w_well_formed && w_byte_match) begin
              exp_d  = exp_q + 8'd1;  // 0xFF wraps to 0x00 naturally
              cons_d = '0;
            end else begin
              if (ec_q != '1) ec_d = ec_q + CNT_W'(1);
              pulse_d = 1'b1;
              exp_d   = DataIn[PAT_BYTE_W-1:0] + 8'd1;  // self-resync
              cons_d  = w_cons_inc;
              if (!fev_q) begin
                fed_d = DataIn;
                fev_d = 1'b1;
              end
              if (w_cons_inc == CONS_W'(LOSS_THRESH)) begin
                locked_d = 1'b0;
                state_d  = ST_SYNC;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      en_ok_q  <= 1'b0;
      locked_q <= 1'b0;
      wc_q     <= '0;
      ec_q     <= '0;
      pulse_q  <= 1'b0;
      fed_q    <= '0;
      fev_q    <= 1'b0;
      exp_q    <= '0;
      cons_q   <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= En;
      en_ok_q  <= en_ok_q || !En;
      locked_q <= locked_d;
      wc_q     <= wc_d;
      ec_q     <= ec_d;
      pulse_q  <= pulse_d;
      fed_q    <= fed_d;
      fev_q    <= fev_d;
      exp_q    <= exp_d;
      cons_q   <= cons_d;
    end
  end

  assign Locked        = locked_q;
  assign WordCount     = wc_q;
  assign ErrCount      = ec_q;
  assign ErrPulse      = pulse_q;
  assign FirstErrData  = fed_q;
  assign FirstErrValid = fev_q;

endmodule : sim_data_checker
`default_nettype wire
